change_dispenser: RTL and testbench

Payout sequencer downstream of the vending controller's change/refund computation. Accepts a change amount in cents over a valid/ready handshake and breaks it into dimes and nickels against a tracked coin inventory. Drives one hopper motor at a time and confirms each coin with a drop sensor. Reports completion, short payment and hopper faults.

---
 rtl/change_dispenser.sv | 180 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change amount in dimes and nickels from a tracked coin
// inventory. It drives one hopper motor at a time and waits for the
// matching drop sensor to confirm each coin before it selects the next one.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_amount[N]               cents to pay, sampled on handshake
//   dime_motor, nickel_motor    hopper drives (never both high)
//   dime_sense, nickel_sense    one-cycle drop confirmations
//   refill_dime, refill_nickel  +1 coin to inventory per asserted cycle
//   dime_stock, nickel_stock    current inventory
//   owed[N]                     cents still unpaid for current/last request
//   done, short                 finish pulse; short = unpaid remainder
//   fault                       sticky hopper timeout (cleared by reset)
module change_dispenser #(
  parameter int N            = 6,
  parameter int STOCK_W      = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [N-1:0]       req_amount,
  output logic               dime_motor,
  output logic               nickel_motor,
  input  logic               dime_sense,
  input  logic               nickel_sense,
  input  logic               refill_dime,
  input  logic               refill_nickel,
  output logic [STOCK_W-1:0] dime_stock,
  output logic [STOCK_W-1:0] nickel_stock,
  output logic [N-1:0]       owed,
  output logic               done,
  output logic               short,
  output logic               fault
);

  localparam int PC_W = $clog2(PULSE_CYCLES + 1);
  localparam int WC_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DRIVE,
    WAIT,
    DONE,
    FAULT
  } state_t;

  state_t             state_reg, state_next;
  logic               coin_dime_reg, coin_dime_next;  // 1 = dime selected
  logic [PC_W-1:0]    pulse_cnt_reg, pulse_cnt_next;
  logic [WC_W-1:0]    wait_cnt_reg, wait_cnt_next;
  logic [N-1:0]       owed_reg, owed_next;
  logic [STOCK_W-1:0] dime_stock_reg, dime_stock_next;
  logic [STOCK_W-1:0] nickel_stock_reg, nickel_stock_next;

  logic               sense_match;
  logic               dime_dec;
  logic               nickel_dec;
  logic [N-1:0]       amount_rem;

  // Saturating increment on refill; a simultaneous dispense cancels it.
  function automatic logic [STOCK_W-1:0] stock_update(
    input logic [STOCK_W-1:0] s,
    input logic               inc,
    input logic               dec
  );
    logic [STOCK_W-1:0] r;
    r = s;
    if (inc && !dec) begin
      if (s != {STOCK_W{1'b1}}) r = s + STOCK_W'(1);
    end else if (dec && !inc) begin
      r = s - STOCK_W'(1);
    end
    return r;
  endfunction

  assign sense_match = coin_dime_reg ? dime_sense : nickel_sense;
  assign amount_rem  = req_amount % N'(5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      coin_dime_reg    <= 1'b0;
      pulse_cnt_reg    <= '0;
      wait_cnt_reg     <= '0;
      owed_reg         <= '0;
      dime_stock_reg   <= '0;
      nickel_stock_reg <= '0;
    end else begin
      state_reg        <= state_next;
      coin_dime_reg    <= coin_dime_next;
      pulse_cnt_reg    <= pulse_cnt_next;
      wait_cnt_reg     <= wait_cnt_next;
      owed_reg         <= owed_next;
      dime_stock_reg   <= dime_stock_next;
      nickel_stock_reg <= nickel_stock_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    coin_dime_next = coin_dime_reg;
    pulse_cnt_next = pulse_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    owed_next      = owed_reg;
    dime_dec       = 1'b0;
    nickel_dec     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          // Sub-nickel cents can never be paid, so drop them up front.
          owed_next  = req_amount - amount_rem;
          state_next = SELECT;
        end
      end
      SELECT: begin
        pulse_cnt_next = '0;
        wait_cnt_next  = '0;
        if (owed_reg == '0) begin
          state_next = DONE;
        end else if (owed_reg >= N'(10) && dime_stock_reg != '0) begin
          coin_dime_next = 1'b1;
          state_next     = DRIVE;
        end else if (owed_reg >= N'(5) && nickel_stock_reg != '0) begin
          coin_dime_next = 1'b0;
          state_next     = DRIVE;
        end else begin
          state_next = DONE;  // short: remaining coins cannot be paid exactly
        end
      end
      DRIVE, WAIT: begin
        if (sense_match) begin
          // Confirmation wins over pulse end and over the timeout.
          owed_next  = owed_reg - (coin_dime_reg ? N'(10) : N'(5));
          dime_dec   = coin_dime_reg;
          nickel_dec = !coin_dime_reg;
          state_next = SELECT;
        end else if (state_reg == DRIVE) begin
          if (pulse_cnt_reg == PC_W'(PULSE_CYCLES - 1)) begin
            state_next = WAIT;
          end else begin
            pulse_cnt_next = pulse_cnt_reg + PC_W'(1);
          end
        end else begin
          if (wait_cnt_reg == WC_W'(ACK_TIMEOUT - 1)) begin
            state_next = FAULT;
          end else begin
            wait_cnt_next = wait_cnt_reg + WC_W'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase

    dime_stock_next   = stock_update(dime_stock_reg, refill_dime, dime_dec);
    nickel_stock_next = stock_update(nickel_stock_reg, refill_nickel, nickel_dec);
  end

  // Outputs decode the registered state, so an asynchronous reset drops
  // the motors immediately.
  assign req_ready    = (state_reg == IDLE);
  assign dime_motor   = (state_reg == DRIVE) && coin_dime_reg;
  assign nickel_motor = (state_reg == DRIVE) && !coin_dime_reg;
  assign done         = (state_reg == DONE);
  assign short        = done && (owed_reg != '0);
  assign fault        = (state_reg == FAULT);
  assign dime_stock   = dime_stock_reg;
  assign nickel_stock = nickel_stock_reg;
  assign owed         = owed_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a table of payout scenarios
// with an automatic drop-sensor responder, plus hand-written sequences for
// reset, zero request timing, timeout, late confirmation and saturation.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_amount = '0;
  logic       dime_motor, nickel_motor;
  logic       dime_sense = 1'b0, nickel_sense = 1'b0;
  logic       refill_dime = 1'b0, refill_nickel = 1'b0;
  logic [7:0] dime_stock, nickel_stock;
  logic [5:0] owed;
  logic       done, short, fault;

  int checks = 0;
  int failures = 0;

  change_dispenser #(.N(6), .STOCK_W(8), .PULSE_CYCLES(4), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
    .dime_motor(dime_motor), .nickel_motor(nickel_motor),
    .dime_sense(dime_sense), .nickel_sense(nickel_sense),
    .refill_dime(refill_dime), .refill_nickel(refill_nickel),
    .dime_stock(dime_stock), .nickel_stock(nickel_stock),
    .owed(owed), .done(done), .short(short), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dimes;
    int nickels;
    int amount;
    bit wrong_sense;        // pulse nickel_sense while a dime motor runs
    bit refill_on_confirm;  // refill a dime in the same cycle as its sense
    int exp_dp;
    int exp_np;
    bit exp_short;
    int exp_owed;
    int exp_ds;
    int exp_ns;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    dime_sense = 1'b0;
    nickel_sense = 1'b0;
    refill_dime = 1'b0;
    refill_nickel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic refill(input int d, input int n);
    for (int i = 0; i < ((d > n) ? d : n); i++) begin
      @(negedge clk);
      refill_dime = (i < d);
      refill_nickel = (i < n);
    end
    @(negedge clk);
    refill_dime = 1'b0;
    refill_nickel = 1'b0;
  endtask

  // Returns at the negedge right after the handshake edge (state SELECT).
  task automatic handshake(input int amount);
    req_valid = 1'b1;
    req_amount = 6'(amount);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_dime_motor(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dime_motor) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int  run_len, pending, dp, np, bad_width, both, cur_coin;
    bit  seen, got_short;
    int  got_owed, got_ds, got_ns;
    string tag;
    run_len = 0; pending = -1; dp = 0; np = 0; bad_width = 0; both = 0; cur_coin = 0;
    seen = 1'b0; got_short = 1'b0; got_owed = 0; got_ds = 0; got_ns = 0;
    do_reset();
    refill(v.dimes, v.nickels);
    handshake(v.amount);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      dime_sense = 1'b0;
      nickel_sense = 1'b0;
      refill_dime = 1'b0;
      if (dime_motor && nickel_motor) both++;
      if (done) begin
        seen = 1'b1;
        got_short = short;
        got_owed = int'(owed);
        got_ds = int'(dime_stock);
        got_ns = int'(nickel_stock);
        break;
      end
      if (dime_motor || nickel_motor) begin
        run_len++;
        cur_coin = dime_motor ? 1 : 0;
        if (v.wrong_sense && dime_motor && run_len == 2) nickel_sense = 1'b1;
      end else if (run_len > 0) begin
        if (run_len != 4) bad_width++;
        if (cur_coin == 1) dp++; else np++;
        run_len = 0;
        pending = 2;
      end
      if (pending == 0) begin
        if (cur_coin == 1) begin
          dime_sense = 1'b1;
          if (v.refill_on_confirm) refill_dime = 1'b1;
        end else begin
          nickel_sense = 1'b1;
        end
        pending = -1;
      end else if (pending > 0) begin
        pending--;
      end
    end
    dime_sense = 1'b0;
    nickel_sense = 1'b0;
    refill_dime = 1'b0;
    tag = $sformatf("vec%0d", idx);
    check({tag, "_done_seen"}, longint'(seen), 1);
    check({tag, "_short"}, longint'(got_short), longint'(v.exp_short));
    check({tag, "_owed"}, got_owed, v.exp_owed);
    check({tag, "_dime_stock"}, got_ds, v.exp_ds);
    check({tag, "_nickel_stock"}, got_ns, v.exp_ns);
    check({tag, "_dime_pulses"}, dp, v.exp_dp);
    check({tag, "_nickel_pulses"}, np, v.exp_np);
    check({tag, "_pulse_width_errs"}, bad_width, 0);
    check({tag, "_both_motors"}, both, 0);
    $display("vector %0d: d=%0d n=%0d amt=%0d -> dp=%0d np=%0d short=%0d owed=%0d ds=%0d ns=%0d",
             idx, v.dimes, v.nickels, v.amount, dp, np, got_short, got_owed, got_ds, got_ns);
  endtask

  initial begin
    bit ok;
    int first_fault;
    bit done_seen;

    //            d  n  amt wr rf dp np sh owed ds ns
    vecs[0]  = '{3, 3, 25, 0, 0, 2, 1, 0, 0,  1, 2};
    vecs[1]  = '{0, 4, 15, 0, 0, 0, 3, 0, 0,  0, 1};
    vecs[2]  = '{2, 0, 15, 0, 0, 1, 0, 1, 5,  1, 0};
    vecs[3]  = '{0, 3, 17, 0, 0, 0, 3, 0, 0,  0, 0};
    vecs[4]  = '{0, 2, 17, 0, 0, 0, 2, 1, 5,  0, 0};
    vecs[5]  = '{3, 0, 5,  0, 0, 0, 0, 1, 5,  3, 0};
    vecs[6]  = '{2, 1, 10, 1, 0, 1, 0, 0, 0,  1, 1};
    vecs[7]  = '{2, 0, 10, 0, 1, 1, 0, 0, 0,  2, 0};
    vecs[8]  = '{0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0};
    vecs[9]  = '{3, 0, 63, 0, 0, 3, 0, 1, 30, 0, 0};
    vecs[10] = '{1, 1, 19, 0, 0, 1, 1, 0, 0,  0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_motors", {dime_motor, nickel_motor}, 0);
    check("rst_done_short_fault", {done, short, fault}, 0);
    check("rst_stocks", {dime_stock, nickel_stock}, 0);
    check("rst_owed", owed, 0);
    $display("reset: ready=%0d owed=%0d", req_ready, owed);

    for (int i = 0; i < 11; i++) run_vector(vecs[i], i);

    // Asynchronous reset during DRIVE
    do_reset();
    refill(1, 0);
    handshake(10);
    wait_dime_motor(ok);
    check("mid_reset_motor_started", longint'(ok), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_motors", {dime_motor, nickel_motor}, 0);
    check("mid_reset_flags", {done, short, fault}, 0);
    check("mid_reset_stocks", {dime_stock, nickel_stock}, 0);
    check("mid_reset_owed", owed, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_ready", req_ready, 1);
    $display("async reset mid-drive: motor=%0d ready=%0d", dime_motor, req_ready);

    // Zero request timing: SELECT, then done, then ready
    do_reset();
    @(negedge clk);
    handshake(0);
    check("zero_select_ready", req_ready, 0);
    check("zero_select_done", done, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_short", short, 0);
    check("zero_motors", {dime_motor, nickel_motor}, 0);
    @(negedge clk);
    check("zero_ready_after", req_ready, 1);
    check("zero_done_after", done, 0);
    $display("zero request: done then ready=%0d", req_ready);

    // Timeout: no sense after a dime pulse
    do_reset();
    refill(1, 0);
    handshake(10);
    wait_dime_motor(ok);
    check("timeout_motor_started", longint'(ok), 1);
    first_fault = -1;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (fault) begin
        first_fault = t;
        break;
      end
    end
    check("timeout_cycles", first_fault, 259);
    check("timeout_motors", {dime_motor, nickel_motor}, 0);
    check("timeout_ready", req_ready, 0);
    check("timeout_dime_stock", dime_stock, 1);
    check("timeout_owed", owed, 10);
    done_seen = 1'b0;
    req_valid = 1'b1;
    req_amount = 6'd20;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    req_valid = 1'b0;
    check("fault_ignores_req_owed", owed, 10);
    check("fault_sticky", fault, 1);
    check("fault_no_done", longint'(done_seen), 0);
    $display("timeout: fault after %0d cycles, owed=%0d", first_fault, owed);

    // Latest accepted sense: last WAIT cycle
    do_reset();
    refill(1, 0);
    handshake(10);
    wait_dime_motor(ok);
    check("late_motor_started", longint'(ok), 1);
    for (int t = 1; t <= 258; t++) @(negedge clk);
    dime_sense = 1'b1;
    @(negedge clk);
    dime_sense = 1'b0;
    check("late_no_fault", fault, 0);
    @(negedge clk);
    check("late_done", done, 1);
    check("late_short", short, 0);
    check("late_dime_stock", dime_stock, 0);
    $display("late sense: done=%0d fault=%0d", done, fault);

    // Saturation and sense in IDLE
    do_reset();
    refill_dime = 1'b1;
    repeat (300) @(negedge clk);
    refill_dime = 1'b0;
    check("sat_dime_stock", dime_stock, 255);
    dime_sense = 1'b1;
    nickel_sense = 1'b1;
    @(negedge clk);
    dime_sense = 1'b0;
    nickel_sense = 1'b0;
    @(negedge clk);
    check("idle_sense_dime_stock", dime_stock, 255);
    check("idle_sense_nickel_stock", nickel_stock, 0);
    check("idle_sense_owed", owed, 0);
    $display("saturation: dime_stock=%0d", dime_stock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
